ana_status_rx: RTL and testbench

// Digital-side receiver for status bits returned from the 3.3 V analog domain

---
 rtl/ana_status_rx_pkg.sv | 19 +
 rtl/ana_status_rx_if.sv | 35 +++
 rtl/ana_status_rx_deb_bit.sv | 107 ++++++++++
 rtl/ana_status_rx.sv | 58 +++++
 tb/tb_ana_status_rx.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ana_status_rx_pkg.sv
// Shared types and constants for the analog status receiver.
// Debouncer state encoding and the minimum usable debounce length.
package ana_rx_pkg;

    typedef enum logic [1:0] {
        S_LO     = 2'd0,
        S_CHK_HI = 2'd1,
        S_HI     = 2'd2,
        S_CHK_LO = 2'd3
    } deb_state_t;

    localparam int ANA_RX_DEB_MIN = 2;

    // States in which the accepted level is high
    function automatic logic is_high_state(input deb_state_t s);
        return (s == S_HI) || (s == S_CHK_LO);
    endfunction

endpackage

// File: rtl/ana_status_rx_if.sv
// Bus between the digital core and the analog status receiver.
// The core is the master; the receiver is the slave.
interface ana_status_rx_if #(
    parameter int N_BITS = 4
);

    logic [N_BITS-1:0] ana_in;
    logic              en;
    logic [N_BITS-1:0] flag_clr;
    logic [N_BITS-1:0] stat_o;
    logic [N_BITS-1:0] rise_flag;
    logic [N_BITS-1:0] fall_flag;
    logic              irq;

    modport master (
        output ana_in,
        output en,
        output flag_clr,
        input  stat_o,
        input  rise_flag,
        input  fall_flag,
        input  irq
    );

    modport slave (
        input  ana_in,
        input  en,
        input  flag_clr,
        output stat_o,
        output rise_flag,
        output fall_flag,
        output irq
    );

endinterface

// File: rtl/ana_status_rx_deb_bit.sv
// One status bit: 2-flop synchroniser followed by a debounce FSM.
// stat_o is registered and tracks the accepted (debounced) level.
module ana_deb_bit
    import ana_rx_pkg::*;
#(
    parameter int DEB_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ana_in,
    output logic stat_o
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    if (DEB_CYC < ANA_RX_DEB_MIN) begin : g_deb_too_short
        $error("ana_deb_bit: DEB_CYC must be at least ANA_RX_DEB_MIN");
    end

    logic             sync1;
    logic             sync2;
    deb_state_t       state_q;
    deb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stat_q;

    // The synchroniser keeps running while disabled so re-enable sees a settled level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ana_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            stat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stat_q  <= is_high_state(state_d);
        end
    end

    // A candidate level must hold for DEB_CYC synced cycles before it is accepted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = S_LO;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_LO: begin
                    if (sync2) begin
                        state_d = S_CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_CHK_HI: begin
                    if (!sync2) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HI: begin
                    if (!sync2) begin
                        state_d = S_CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_CHK_LO: begin
                    if (sync2) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign stat_o = stat_q;

endmodule

// File: rtl/ana_status_rx.sv
// Receiver for level-shifted analog status bits: per-bit debouncers,
// sticky rise/fall flags and a combined interrupt.
module ana_status_rx
    import ana_rx_pkg::*;
#(
    parameter int N_BITS  = 4,
    parameter int DEB_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ana_status_rx_if.slave    bus
);

    logic [N_BITS-1:0] stat;
    logic [N_BITS-1:0] stat_prev;
    logic [N_BITS-1:0] rise_q;
    logic [N_BITS-1:0] fall_q;
    logic [N_BITS-1:0] rise_set;
    logic [N_BITS-1:0] fall_set;
    logic              en_q;

    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
        ana_deb_bit #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bus.en),
            .ana_in (bus.ana_in[i]),
            .stat_o (stat[i])
        );
    end

    // en_q remembers whether the last stat update was a forced clear, which must not flag a fall
    assign rise_set = stat & ~stat_prev;
    assign fall_set = ~stat & stat_prev & {N_BITS{en_q}};

    // Set beats clear when both hit the same bit in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_prev <= '0;
            en_q      <= 1'b0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            stat_prev <= stat;
            en_q      <= bus.en;
            rise_q    <= (rise_q & ~bus.flag_clr) | rise_set;
            fall_q    <= (fall_q & ~bus.flag_clr) | fall_set;
        end
    end

    assign bus.stat_o    = stat;
    assign bus.rise_flag = rise_q;
    assign bus.fall_flag = fall_q;
    assign bus.irq       = |(rise_q | fall_q);

endmodule

// File: tb/tb_ana_status_rx.sv
// Directed bench for ana_status_rx with DEB_CYC=8 and four status bits.
module tb_ana_status_rx;

    localparam int N_BITS  = 4;
    localparam int DEB_CYC = 8;

    logic clk = 1'b0;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ana_status_rx_if #(.N_BITS(N_BITS)) bus ();

    ana_status_rx #(
        .N_BITS  (N_BITS),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] ana, input logic en, input logic [3:0] clr);
        bus.ana_in   = ana;
        bus.en       = en;
        bus.flag_clr = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset(input logic [3:0] ana);
        rst_n = 1'b0;
        applyStimulus(ana, 1'b1, 4'h0);
        tick(2);
        rst_n = 1'b1;
    endtask

    // Safety net in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        $display("[TB] reset and first qualification");
        rst_n = 1'b0;
        applyStimulus(4'hF, 1'b1, 4'h0);
        tick(2);
        checkOutput("rst_stat", 32'(bus.stat_o), 32'h0);
        checkOutput("rst_rise", 32'(bus.rise_flag), 32'h0);
        checkOutput("rst_fall", 32'(bus.fall_flag), 32'h0);
        checkOutput("rst_irq", 32'(bus.irq), 32'h0);
        rst_n = 1'b1;
        tick(9);
        checkOutput("t1_stat_edge9", 32'(bus.stat_o), 32'h0);
        tick(1);
        checkOutput("t1_stat_edge10", 32'(bus.stat_o), 32'hF);
        checkOutput("t1_rise_edge10", 32'(bus.rise_flag), 32'h0);
        tick(1);
        checkOutput("t1_rise_edge11", 32'(bus.rise_flag), 32'hF);
        checkOutput("t1_irq", 32'(bus.irq), 32'h1);
        checkOutput("t1_fall", 32'(bus.fall_flag), 32'h0);

        $display("[TB] glitch rejection on bit 0");
        doReset(4'h0);
        tick(3);
        applyStimulus(4'h1, 1'b1, 4'h0);
        tick(7);
        applyStimulus(4'h0, 1'b1, 4'h0);
        tick(12);
        checkOutput("t2_glitch7_stat", 32'(bus.stat_o), 32'h0);
        checkOutput("t2_glitch7_rise", 32'(bus.rise_flag), 32'h0);
        checkOutput("t2_glitch7_irq", 32'(bus.irq), 32'h0);
        applyStimulus(4'h1, 1'b1, 4'h0);
        tick(8);
        applyStimulus(4'h0, 1'b1, 4'h0);
        tick(1);
        checkOutput("t2_pulse8_stat_edge9", 32'(bus.stat_o), 32'h0);
        tick(1);
        checkOutput("t2_pulse8_stat_edge10", 32'(bus.stat_o), 32'h1);
        tick(1);
        checkOutput("t2_pulse8_rise", 32'(bus.rise_flag), 32'h1);
        checkOutput("t2_pulse8_irq", 32'(bus.irq), 32'h1);

        $display("[TB] fall flag and clear on bit 2");
        doReset(4'h0);
        tick(3);
        applyStimulus(4'h4, 1'b1, 4'h0);
        tick(12);
        checkOutput("t3_stat_high", 32'(bus.stat_o), 32'h4);
        checkOutput("t3_rise", 32'(bus.rise_flag), 32'h4);
        applyStimulus(4'h4, 1'b1, 4'h4);
        tick(1);
        applyStimulus(4'h0, 1'b1, 4'h0);
        checkOutput("t3_rise_cleared", 32'(bus.rise_flag), 32'h0);
        checkOutput("t3_irq_after_rise_clr", 32'(bus.irq), 32'h0);
        tick(9);
        checkOutput("t3_stat_still_high", 32'(bus.stat_o), 32'h4);
        checkOutput("t3_fall_not_yet", 32'(bus.fall_flag), 32'h0);
        tick(1);
        checkOutput("t3_stat_low", 32'(bus.stat_o), 32'h0);
        tick(1);
        checkOutput("t3_fall_set", 32'(bus.fall_flag), 32'h4);
        checkOutput("t3_irq_fall", 32'(bus.irq), 32'h1);
        checkOutput("t3_rise_quiet", 32'(bus.rise_flag), 32'h0);
        applyStimulus(4'h0, 1'b1, 4'h4);
        tick(1);
        applyStimulus(4'h0, 1'b1, 4'h0);
        checkOutput("t3_fall_cleared", 32'(bus.fall_flag), 32'h0);
        checkOutput("t3_irq_dropped", 32'(bus.irq), 32'h0);

        $display("[TB] set and clear collision on bit 1");
        doReset(4'h0);
        tick(3);
        applyStimulus(4'h2, 1'b1, 4'h0);
        tick(9);
        checkOutput("t4_stat_edge9", 32'(bus.stat_o), 32'h0);
        tick(1);
        checkOutput("t4_stat_edge10", 32'(bus.stat_o), 32'h2);
        checkOutput("t4_rise_before", 32'(bus.rise_flag), 32'h0);
        applyStimulus(4'h2, 1'b1, 4'h2);
        tick(1);
        applyStimulus(4'h2, 1'b1, 4'h0);
        checkOutput("t4_collision_rise", 32'(bus.rise_flag), 32'h2);
        checkOutput("t4_collision_irq", 32'(bus.irq), 32'h1);
        applyStimulus(4'h2, 1'b1, 4'h2);
        tick(1);
        applyStimulus(4'h2, 1'b1, 4'h0);
        checkOutput("t4_plain_clear", 32'(bus.rise_flag), 32'h0);

        $display("[TB] enable gating");
        doReset(4'hF);
        tick(11);
        checkOutput("t5_stat_high", 32'(bus.stat_o), 32'hF);
        checkOutput("t5_rise_high", 32'(bus.rise_flag), 32'hF);
        applyStimulus(4'hF, 1'b0, 4'h0);
        tick(1);
        checkOutput("t5_stat_forced_low", 32'(bus.stat_o), 32'h0);
        checkOutput("t5_fall_edge1", 32'(bus.fall_flag), 32'h0);
        tick(1);
        checkOutput("t5_fall_edge2", 32'(bus.fall_flag), 32'h0);
        checkOutput("t5_rise_hold", 32'(bus.rise_flag), 32'hF);
        applyStimulus(4'hF, 1'b0, 4'hF);
        tick(1);
        applyStimulus(4'hF, 1'b0, 4'h0);
        checkOutput("t5_clr_while_off", 32'(bus.rise_flag), 32'h0);
        checkOutput("t5_irq_off", 32'(bus.irq), 32'h0);
        applyStimulus(4'hF, 1'b1, 4'h0);
        tick(7);
        checkOutput("t5_requal_edge7", 32'(bus.stat_o), 32'h0);
        tick(1);
        checkOutput("t5_requal_edge8", 32'(bus.stat_o), 32'hF);
        tick(1);
        checkOutput("t5_rise_reset", 32'(bus.rise_flag), 32'hF);
        checkOutput("t5_fall_final", 32'(bus.fall_flag), 32'h0);

        $display("[TB] async reset mid-count");
        applyStimulus(4'hF, 1'b1, 4'hF);
        tick(1);
        applyStimulus(4'h0, 1'b1, 4'h0);
        checkOutput("t6_rise_cleared", 32'(bus.rise_flag), 32'h0);
        tick(7);
        checkOutput("t6_stat_before", 32'(bus.stat_o), 32'hF);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_stat_async", 32'(bus.stat_o), 32'h0);
        checkOutput("t6_rise_async", 32'(bus.rise_flag), 32'h0);
        checkOutput("t6_fall_async", 32'(bus.fall_flag), 32'h0);
        checkOutput("t6_irq_async", 32'(bus.irq), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        checkOutput("t6_stat_quiet", 32'(bus.stat_o), 32'h0);
        checkOutput("t6_fall_quiet", 32'(bus.fall_flag), 32'h0);
        checkOutput("t6_irq_quiet", 32'(bus.irq), 32'h0);
        applyStimulus(4'hF, 1'b1, 4'h0);
        tick(9);
        checkOutput("t6_requal_edge9", 32'(bus.stat_o), 32'h0);
        tick(1);
        checkOutput("t6_requal_edge10", 32'(bus.stat_o), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
